// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file: NUM_REGS general registers plus one working
// register reachable only through port B and the write port, with write-to-read bypass.
module reg_file_2r1w #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_REGS  = 28,
    parameter int unsigned SEL_A_W   = 5,
    parameter int unsigned SEL_B_W   = 6,
    parameter int unsigned WREG_ADDR = 34
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic [SEL_A_W-1:0] sel_a,
    input  logic [SEL_B_W-1:0] sel_b,
    input  logic               wr_en,
    input  logic [SEL_B_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]  data_a,
    output logic [DATA_W-1:0]  data_b,
    output logic               rd_valid,
    output logic               addr_err
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] wreg_q;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              wr_gen_c, wr_wreg_c;
    logic              a_gen_c, b_gen_c, b_wreg_c;
    logic [IDX_W-1:0]  wr_idx_c, a_idx_c, b_idx_c;

    // Address decode for the write port and both read selects
    always_comb begin
        wr_gen_c  = wr_en && (32'(wr_addr) < NUM_REGS);
        wr_wreg_c = wr_en && (wr_addr == SEL_B_W'(WREG_ADDR));
        a_gen_c   = 32'(sel_a) < NUM_REGS;
        b_gen_c   = 32'(sel_b) < NUM_REGS;
        b_wreg_c  = sel_b == SEL_B_W'(WREG_ADDR);
        wr_idx_c  = IDX_W'(wr_addr);
        a_idx_c   = IDX_W'(sel_a);
        b_idx_c   = IDX_W'(sel_b);
    end

    // Next-state for the read outputs; a same-edge write to the selected register wins
    always_comb begin
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        rd_valid_d = rd_en;
        addr_err_d = (rd_en && (!a_gen_c || !(b_gen_c || b_wreg_c)))
                  || (wr_en && !(wr_gen_c || wr_wreg_c));
        if (rd_en) begin
            data_a_d = '0;
            if (a_gen_c) begin
                if (wr_gen_c && (32'(wr_addr) == 32'(sel_a))) data_a_d = wr_data;
                else                                          data_a_d = regs_q[a_idx_c];
            end
            data_b_d = '0;
            if (b_gen_c) begin
                if (wr_gen_c && (wr_addr == sel_b)) data_b_d = wr_data;
                else                                data_b_d = regs_q[b_idx_c];
            end else if (b_wreg_c) begin
                if (wr_wreg_c) data_b_d = wr_data;
                else           data_b_d = wreg_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            wreg_q     <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            if (wr_gen_c)  regs_q[wr_idx_c] <= wr_data;
            if (wr_wreg_c) wreg_q           <= wr_data;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign data_a   = data_a_q;
    assign data_b   = data_b_q;
    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: hand-computed expectations checked with
// immediate assertions one cycle after each driven edge.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [4:0]  sel_a;
    logic [5:0]  sel_b;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        rd_valid;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_regs [28];

    reg_file_2r1w dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .data_a   (data_a),
        .data_b   (data_b),
        .rd_valid (rd_valid),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d; rd_en = 1'b0;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [5:0] b);
        rd_en = 1'b1; sel_a = a; sel_b = b; wr_en = 1'b0;
        cyc();
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        sel_a = '0; sel_b = '0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 28; i++) exp_regs[i] = 16'h0000;

        // Reset state
        #12;
        chk("rst_data_a", data_a, 16'h0);
        chk("rst_data_b", data_b, 16'h0);
        chk("rst_rd_valid", 16'(rd_valid), 16'h0);
        chk("rst_addr_err", 16'(addr_err), 16'h0);
        rst_n = 1'b1;

        // Write r5 then read it on both ports
        do_write(6'd5, 16'h1234); exp_regs[5] = 16'h1234;
        chk("wr_r5_err", 16'(addr_err), 16'h0);
        chk("wr_r5_valid", 16'(rd_valid), 16'h0);
        do_read(5'd5, 6'd5);
        chk("rd_r5_a", data_a, 16'h1234);
        chk("rd_r5_b", data_b, 16'h1234);
        chk("rd_r5_valid", 16'(rd_valid), 16'h1);
        chk("rd_r5_err", 16'(addr_err), 16'h0);
        cyc();
        chk("idle_valid", 16'(rd_valid), 16'h0);
        chk("idle_hold_a", data_a, 16'h1234);

        // Working register, and an unmapped port-B select
        do_write(6'd34, 16'hBEEF);
        do_read(5'd0, 6'd34);
        chk("wreg_b", data_b, 16'hBEEF);
        chk("wreg_a_r0", data_a, 16'h0000);
        chk("wreg_err", 16'(addr_err), 16'h0);
        do_read(5'd5, 6'd33);
        chk("b33_data_b", data_b, 16'h0000);
        chk("b33_err", 16'(addr_err), 16'h1);
        chk("b33_valid", 16'(rd_valid), 16'h1);
        cyc();
        chk("b33_err_drop", 16'(addr_err), 16'h0);

        // Same-edge bypass on both ports
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 16'h00AA;
        rd_en = 1'b1; sel_a = 5'd7; sel_b = 6'd34;
        cyc(); idle(); exp_regs[7] = 16'h00AA;
        chk("byp_a", data_a, 16'h00AA);
        chk("byp_b_wreg_old", data_b, 16'hBEEF);
        wr_en = 1'b1; wr_addr = 6'd34; wr_data = 16'hCAFE;
        rd_en = 1'b1; sel_a = 5'd7; sel_b = 6'd34;
        cyc(); idle();
        chk("byp_b_wreg", data_b, 16'hCAFE);
        chk("byp_a_r7", data_a, 16'h00AA);

        // Hold while rd_en is low, writes continue underneath
        do_write(6'd3, 16'h1111);
        do_read(5'd3, 6'd3);
        chk("r3_old", data_a, 16'h1111);
        for (int k = 0; k < 3; k++) begin
            do_write(6'd3, 16'h5555);
            chk("hold_a", data_a, 16'h1111);
            chk("hold_valid", 16'(rd_valid), 16'h0);
        end
        exp_regs[3] = 16'h5555;
        do_read(5'd3, 6'd3);
        chk("r3_new", data_a, 16'h5555);

        // Port-A select beyond the general registers
        do_read(5'd30, 6'd5);
        chk("a30_data_a", data_a, 16'h0000);
        chk("a30_data_b", data_b, 16'h1234);
        chk("a30_err", 16'(addr_err), 16'h1);
        chk("a30_valid", 16'(rd_valid), 16'h1);

        // Invalid write, then back-to-back dump of every register
        do_write(6'd40, 16'hFFFF);
        chk("w40_err", 16'(addr_err), 16'h1);
        rd_en = 1'b1;
        for (int i = 0; i < 28; i++) begin
            sel_a = 5'(i); sel_b = 6'(i);
            cyc();
            chk("dump_a", data_a, exp_regs[i]);
            chk("dump_b", data_b, exp_regs[i]);
            chk("dump_valid", 16'(rd_valid), 16'h1);
            chk("dump_err", 16'(addr_err), 16'h0);
        end
        sel_b = 6'd34;
        cyc();
        chk("dump_wreg", data_b, 16'hCAFE);
        chk("dump_wreg_valid", 16'(rd_valid), 16'h1);

        // Reset mid-cycle during continuous reads; write under reset is dropped
        sel_a = 5'd5; sel_b = 6'd5;
        cyc();
        chk("pre_rst_a", data_a, 16'h1234);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_a", data_a, 16'h0);
        chk("mid_rst_b", data_b, 16'h0);
        chk("mid_rst_valid", 16'(rd_valid), 16'h0);
        chk("mid_rst_err", 16'(addr_err), 16'h0);
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 16'h9999;
        cyc();
        chk("in_rst_valid", 16'(rd_valid), 16'h0);
        #2 rst_n = 1'b1;
        idle();
        do_read(5'd5, 6'd34);
        chk("post_rst_a", data_a, 16'h0);
        chk("post_rst_b", data_b, 16'h0);
        chk("post_rst_valid", 16'(rd_valid), 16'h1);
        do_read(5'd9, 6'd9);
        chk("post_rst_r9_a", data_a, 16'h0);
        chk("post_rst_r9_b", data_b, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register and data-port width in bits.
REQ-002 Parameter NUM_REGS, default 28, SHALL set the number of general registers, r0..r(NUM_REGS-1).
REQ-003 Parameter SEL_A_W, default 5, SHALL set the port-A select width; constraint: NUM_REGS <= 2^SEL_A_W.
REQ-004 Parameter SEL_B_W, default 6, SHALL set the port-B and write-address width.
REQ-005 Parameter WREG_ADDR, default 34, SHALL set the working-register address; constraint: NUM_REGS <= WREG_ADDR < 2^SEL_B_W.
REQ-006 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 rd_en  input  1  SHALL be the read strobe, sampled at the rising edge.
REQ-009 sel_a  input  SEL_A_W  SHALL be the port-A register select.
REQ-010 sel_b  input  SEL_B_W  SHALL be the port-B register select, including the working register.
REQ-011 wr_en  input  1  SHALL be the write strobe.
REQ-012 wr_addr  input  SEL_B_W  SHALL be the write address; same map as sel_b.
REQ-013 wr_data  input  DATA_W  SHALL be the write data.
REQ-014 data_a  output  DATA_W  SHALL be the registered port-A read data.
REQ-015 data_b  output  DATA_W  SHALL be the registered port-B read data.
REQ-016 rd_valid  output  1  SHALL flag that data_a and data_b carry a fresh read result.
REQ-017 addr_err  output  1  SHALL flag an out-of-map access.

Function
REQ-018 Storage SHALL be NUM_REGS general registers plus one working register, each DATA_W bits.
REQ-019 With wr_en=1 at an edge, wr_addr<NUM_REGS SHALL write the general register and wr_addr==WREG_ADDR SHALL write the working register; any other address SHALL write nothing.
REQ-020 With rd_en=1 at an edge, data_a and data_b SHALL load the selected values at that edge (latency 1), and rd_valid SHALL be 1 for the following cycle.
REQ-021 With rd_en=0 at an edge, data_a and data_b SHALL hold and rd_valid SHALL be 0.
REQ-022 Back-to-back reads SHALL be accepted every cycle; rd_valid SHALL stay 1 throughout.
REQ-023 Port A SHALL select only general registers; sel_a>=NUM_REGS SHALL load data_a=0.
REQ-024 sel_b<NUM_REGS SHALL select the general register, sel_b==WREG_ADDR the working register, and any other value SHALL load data_b=0.
REQ-025 Bypass: with wr_en and rd_en at the same edge and a valid wr_addr equal to a port's effective select, that port SHALL load wr_data, not the old content.
REQ-026 Both ports selecting the same register SHALL return identical data.
REQ-027 addr_err SHALL be 1 for exactly the cycle after an edge with either (rd_en=1 and an invalid sel_a or sel_b) or (wr_en=1 and an invalid wr_addr); otherwise 0.
REQ-028 An invalid write SHALL leave all storage unchanged; an invalid read SHALL still assert rd_valid.

Reset
REQ-029 rst_n=0 SHALL immediately clear all general registers, the working register, data_a, data_b, rd_valid and addr_err to 0, independent of clk.
REQ-030 A write or read coinciding with asserted reset SHALL be discarded.
REQ-031 The first rising edge after rst_n deasserts SHALL operate normally.

Verification
REQ-032 Write r5=0x1234, then rd_en with sel_a=5, sel_b=5 -> next cycle data_a=data_b=0x1234, rd_valid=1.
REQ-033 Write wr_addr=34 with 0xBEEF, then read sel_b=34 -> data_b=0xBEEF; read sel_b=33 -> data_b=0, addr_err=1 for one cycle.
REQ-034 Same edge: wr_en to r7=0x00AA, rd_en with sel_a=7 -> data_a=0x00AA after that edge.
REQ-035 Read sel_a=3 then drop rd_en for 3 cycles while writing r3=0x5555 -> data_a holds the old value, rd_valid=0.
REQ-036 Write wr_addr=40 with 0xFFFF -> addr_err pulses 1 cycle, no register changes (full dump of r0..r27 and r34 unchanged).
REQ-037 Assert rst_n=0 mid-cycle during continuous reads -> all outputs 0 before the next edge; a subsequent read of any register returns 0.
